// File: rtl/led_sweep_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : led_sweep_monitor
//  Purpose  : Watches a one-hot Knight Rider LED bus, encodes the lit index,
//             tracks direction, counts end arrivals and flags illegal moves.
//  Revision : 1.0  initial release
// ============================================================================
module led_sweep_monitor #(
    parameter int N  = 10,
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          clr,
    input  logic          en,
    input  logic          err_clr,
    input  logic [N-1:0]  led,
    output logic [W-1:0]  pos,
    output logic          valid,
    output logic          dir,
    output logic          step,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] sweeps
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [1:0]    c_ERR_MULTI   = 2'b01;
    localparam logic [1:0]    c_ERR_SKIP    = 2'b10;
    localparam logic [1:0]    c_ERR_REVERSE = 2'b11;
    localparam logic [N-1:0]  c_LED_LSB     = N'(1);
    localparam logic [W:0]    c_POS_INC     = (W+1)'(1);
    localparam logic [W-1:0]  c_POS_TOP     = W'(N-1);
    localparam logic [CW-1:0] c_SWEEP_INC   = CW'(1);

    state_t        r_state;
    logic [N-1:0]  r_sync1, r_led_s, r_led_p;
    logic [W-1:0]  r_pos;
    logic          r_valid, r_dir, r_step, r_err;
    logic [1:0]    r_err_code;
    logic [CW-1:0] r_sweeps;

    logic          w_stable, w_blank, w_multi;
    logic [W-1:0]  w_p;
    logic          w_is_up, w_is_dn, w_fwd, w_back, w_at_top, w_at_bot;
    logic          w_err_hit;
    logic [1:0]    w_err_code;

    assign w_stable = (r_led_s == r_led_p);
    assign w_blank  = (r_led_s == '0);
    assign w_multi  = |(r_led_s & (r_led_s - c_LED_LSB));

    always_comb begin
        w_p = '0;
        for (int i = 0; i < N; i++) begin
            if (r_led_s[i]) w_p = W'(i);
        end
    end

    // Extended by one bit so pos-1 at index 0 cannot wrap into a false match.
    assign w_is_up  = ({1'b0, w_p} == ({1'b0, r_pos} + c_POS_INC));
    assign w_is_dn  = (({1'b0, w_p} + c_POS_INC) == {1'b0, r_pos});
    assign w_fwd    = r_dir ? w_is_dn : w_is_up;
    assign w_back   = r_dir ? w_is_up : w_is_dn;
    assign w_at_top = (w_p == c_POS_TOP);
    assign w_at_bot = (w_p == '0);

    always_comb begin
        w_err_hit  = 1'b0;
        w_err_code = 2'b00;
        if (en && w_stable) begin
            if (w_multi) begin
                w_err_hit  = 1'b1;
                w_err_code = c_ERR_MULTI;
            end else if (!w_blank && (r_state == ST_TRACK) && (w_p != r_pos) && !w_fwd) begin
                w_err_hit  = 1'b1;
                w_err_code = w_back ? c_ERR_REVERSE : c_ERR_SKIP;
            end
        end
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            r_sync1    <= '0;
            r_led_s    <= '0;
            r_led_p    <= '0;
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_valid    <= 1'b0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_sweeps   <= '0;
        end else begin
            r_sync1 <= led;
            r_led_s <= r_sync1;
            r_led_p <= r_led_s;
            r_step  <= 1'b0;

            // A fresh error overrides a simultaneous clear.
            if (w_err_hit) begin
                r_err <= 1'b1;
                if (!r_err || err_clr) r_err_code <= w_err_code;
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end

            if (!en) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end else if (w_stable) begin
                if (w_blank || w_multi) begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end else if (r_state == ST_IDLE) begin
                    r_state <= ST_TRACK;
                    r_valid <= 1'b1;
                    r_pos   <= w_p;
                    r_dir   <= w_at_top;
                end else if (w_p != r_pos) begin
                    r_pos   <= w_p;
                    r_valid <= 1'b1;
                    if (w_fwd) begin
                        r_step <= 1'b1;
                        if (w_at_top || w_at_bot) begin
                            r_dir <= w_at_top;
                            if (r_sweeps != '1) r_sweeps <= r_sweeps + c_SWEEP_INC;
                        end
                    end else begin
                        r_dir <= w_at_top;
                    end
                end
            end
        end
    end

    assign pos      = r_pos;
    assign valid    = r_valid;
    assign dir      = r_dir;
    assign step     = r_step;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign sweeps   = r_sweeps;

endmodule
`default_nettype wire

// File: tb/tb_led_sweep_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_sweep_monitor
//  Purpose  : Scoreboard bench for led_sweep_monitor with a sample-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_sweep_monitor;
    localparam int N = 10, W = 4, CW = 8, H = 8;

    logic CLK = 1'b0, clr = 1'b0, en = 1'b0, err_clr = 1'b0;
    logic [N-1:0] led = '0;
    logic [W-1:0] pos, s_pos;
    logic valid, dir, step, err, s_valid, s_dir, s_step, s_err;
    logic [1:0] err_code, s_err_code, s_sweeps;
    logic [CW-1:0] sweeps;

    always #5 CLK = ~CLK;

    led_sweep_monitor #(.N(N), .W(W), .CW(CW)) u_dut (
        .CLK(CLK), .clr(clr), .en(en), .err_clr(err_clr), .led(led),
        .pos(pos), .valid(valid), .dir(dir), .step(step), .err(err),
        .err_code(err_code), .sweeps(sweeps));

    led_sweep_monitor #(.N(N), .W(W), .CW(2)) u_sat (
        .CLK(CLK), .clr(clr), .en(en), .err_clr(err_clr), .led(led),
        .pos(s_pos), .valid(s_valid), .dir(s_dir), .step(s_step), .err(s_err),
        .err_code(s_err_code), .sweeps(s_sweeps));

    typedef struct {
        logic [W-1:0] pos; logic valid; logic dir; logic err;
        logic [1:0] code; logic [CW-1:0] sweeps; logic [1:0] sat;
    } snap_t;
    typedef struct { logic [W-1:0] pos; logic dir; logic [CW-1:0] sweeps; } stp_t;

    snap_t chk_q[$];
    stp_t  step_q[$];
    int errors = 0, checks = 0;

    // Reference state, updated once per distinct held LED pattern.
    bit m_track, m_dir, m_valid, m_err;
    bit [1:0] m_code;
    int m_pos, m_sweeps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] x;
        x = '0;
        x[i] = 1'b1;
        return x;
    endfunction

    function automatic int one_idx(input logic [N-1:0] v);
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (v[i]) k = i;
        return k;
    endfunction

    function automatic int sat_to(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic m_reset();
        m_track = 0; m_dir = 0; m_valid = 0; m_err = 0; m_code = 2'd0;
        m_pos = 0; m_sweeps = 0;
    endtask

    task automatic m_error(input bit [1:0] c);
        if (!m_err) m_code = c;
        m_err = 1;
    endtask

    task automatic m_eval(input logic [N-1:0] v);
        int k, p, fwd;
        k = $countones(v);
        if (k == 0) begin
            m_track = 0; m_valid = 0;
        end else if (k > 1) begin
            m_error(2'd1); m_track = 0; m_valid = 0;
        end else begin
            p = one_idx(v);
            fwd = m_dir ? -1 : 1;
            if (!m_track) begin
                m_track = 1; m_valid = 1; m_pos = p; m_dir = (p == N-1);
            end else if (p == m_pos + fwd) begin
                m_pos = p;
                if (p == N-1 || p == 0) begin
                    m_dir = (p == N-1);
                    m_sweeps++;
                end
                step_q.push_back('{W'(m_pos), m_dir, CW'(sat_to(m_sweeps, 255))});
            end else if (p != m_pos) begin
                m_error((p == m_pos - fwd) ? 2'd3 : 2'd2);
                m_pos = p; m_dir = (p == N-1);
            end
        end
    endtask

    task automatic push_snap();
        chk_q.push_back('{W'(m_pos), m_valid, m_dir, m_err, m_code,
                          CW'(sat_to(m_sweeps, 255)), 2'(sat_to(m_sweeps, 3))});
        @(negedge CLK);
    endtask

    // One held LED pattern; optional 1-cycle glitch before it and err_clr pulse mid-hold.
    task automatic txn(input logic [N-1:0] v, input bit e, input bit clrmid,
                       input bit glitch, input logic [N-1:0] g);
        en = e;
        if (glitch) begin
            led = g;
            @(negedge CLK);
        end
        led = v;
        if (e) m_eval(v);
        else begin m_track = 0; m_valid = 0; end
        for (int c = 1; c <= H; c++) begin
            @(negedge CLK);
            err_clr = (clrmid && c == 5);
        end
        if (clrmid) begin
            if (e && $countones(v) > 1) begin m_err = 1; m_code = 2'd1; end
            else begin m_err = 0; m_code = 2'd0; end
        end
        push_snap();
    endtask

    task automatic go(input logic [N-1:0] v);
        txn(v, 1'b1, 1'b0, 1'b0, '0);
    endtask

    // err_clr lands on the very edge that first evaluates v.
    task automatic txn_clr_same(input logic [N-1:0] v);
        en = 1'b1;
        led = v;
        repeat (3) @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        m_err = 0; m_code = 2'd0;
        m_eval(v);
        repeat (H - 4) @(negedge CLK);
        push_snap();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pos"},    32'(pos),      32'd0);
        check({tag, "_valid"},  32'(valid),    32'd0);
        check({tag, "_dir"},    32'(dir),      32'd0);
        check({tag, "_step"},   32'(step),     32'd0);
        check({tag, "_err"},    32'(err),      32'd0);
        check({tag, "_code"},   32'(err_code), 32'd0);
        check({tag, "_sweeps"}, 32'(sweeps),   32'd0);
    endtask

    // Monitor: checks every step pulse and every settled snapshot.
    initial begin
        snap_t e;
        stp_t  s;
        forever begin
            @(posedge CLK);
            #2;
            if (step === 1'b1) begin
                if (step_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL step_extra: got pulse at pos %0d expected none", pos);
                end else begin
                    s = step_q.pop_front();
                    check("step_pos",    32'(pos),    32'(s.pos));
                    check("step_dir",    32'(dir),    32'(s.dir));
                    check("step_sweeps", 32'(sweeps), 32'(s.sweeps));
                end
            end
            if (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                check("pos",           32'(pos),      32'(e.pos));
                check("valid",         32'(valid),    32'(e.valid));
                check("dir",           32'(dir),      32'(e.dir));
                check("err",           32'(err),      32'(e.err));
                check("err_code",      32'(err_code), 32'(e.code));
                check("sweeps",        32'(sweeps),   32'(e.sweeps));
                check("sat_sweeps",    32'(s_sweeps), 32'(e.sat));
                check("missing_steps", 32'(step_q.size()), 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cur, v, g;
        bit prev_en, e, gl, cm;
        int r, a, b;
        m_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge CLK);
        clr = 1'b1;
        en  = 1'b1;
        @(negedge CLK);

        // Three full legal sweeps: 54 steps, 6 end arrivals.
        go(onehot(0));
        repeat (3) begin
            for (int p = 1; p < N; p++) go(onehot(p));
            for (int p = N-2; p >= 0; p--) go(onehot(p));
        end
        check("sweeps_after_3", 32'(sweeps),   32'd6);
        check("sat_holds_3",    32'(s_sweeps), 32'd3);
        check("legal_err",      32'(err),      32'd0);

        go(10'h003);
        check("multi_code",  32'(err_code), 32'd1);
        check("multi_valid", 32'(valid),    32'd0);
        go(10'h001);
        txn(10'h001, 1'b1, 1'b1, 1'b0, '0);
        check("clear_err", 32'(err), 32'd0);

        go(10'h002); go(10'h004); go(10'h008);
        go(10'h020);
        check("skip_code", 32'(err_code), 32'd2);
        go(10'h040);
        go(10'h020);
        check("first_wins", 32'(err_code), 32'd2);
        txn(10'h020, 1'b1, 1'b1, 1'b0, '0);

        go(10'h000);
        go(10'h004);
        txn(10'h008, 1'b1, 1'b0, 1'b1, 10'h006);
        txn(10'h010, 1'b1, 1'b0, 1'b1, 10'h000);
        check("glitch_err", 32'(err), 32'd0);

        go(10'h008);
        txn_clr_same(10'h040);
        check("clr_same_code", 32'(err_code), 32'd2);

        cur = 10'h040;
        prev_en = 1'b1;
        repeat (200) begin
            r = $urandom_range(0, 99);
            v = cur; e = 1'b1; gl = 1'b0; g = '0;
            if (!prev_en) v = cur;
            else if (r < 55) v = m_track ? onehot(m_pos + (m_dir ? -1 : 1))
                                         : onehot($urandom_range(0, N-1));
            else if (r < 65) v = cur;
            else if (r < 73) v = onehot($urandom_range(0, N-1));
            else if (r < 80) v = '0;
            else if (r < 86) begin
                a = $urandom_range(0, N-1);
                b = (a + 1 + $urandom_range(0, N-2)) % N;
                v = N'($urandom);
                v[a] = 1'b1; v[b] = 1'b1;
            end else if (r < 92) begin
                e = 1'b0;
                v = onehot($urandom_range(0, N-1));
            end else begin
                gl = 1'b1;
                g = N'($urandom);
                v = m_track ? onehot(m_pos + (m_dir ? -1 : 1)) : onehot($urandom_range(0, N-1));
            end
            cm = ($urandom_range(0, 9) == 0);
            txn(v, e, cm, gl, g);
            cur = v;
            prev_en = e;
        end

        // Asynchronous reset mid-cycle, then re-entry from the held pattern.
        @(posedge CLK);
        #3;
        clr = 1'b0;
        #1;
        check_reset_outputs("async_clr");
        m_reset();
        repeat (2) @(negedge CLK);
        clr = 1'b1;
        go(cur);
        for (int i = 0; i < 6; i++) go(m_track ? onehot(m_pos + (m_dir ? -1 : 1)) : onehot(i));

        repeat (4) @(negedge CLK);
        check("queue_drained", 32'(chk_q.size() + step_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
